// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline-register definitions: word size, bubble value and the
// occupancy encoding used by every inter-stage buffer.
package pipe_stage_buf_pkg;

  localparam int WORD_SIZE = 32;
  localparam logic [WORD_SIZE-1:0] NOP_VALUE = '0;

  // Encoding is also the entry count reported on the occupancy port.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer and
// flush-to-bubble; drop-in for the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int                DATA_W    = WORD_SIZE,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(pipe_stage_buf_pkg::NOP_VALUE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              accept, drain;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign drain     = out_valid & out_ready;
  assign accept    = in_valid & in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      // Ready is a flop so upstream never sees a path from out_ready.
      always_ff @(posedge clk) begin
        if (reset) rdy_q <= 1'b1;
        else       rdy_q <= (state_d != FULL);
      end

      // flush keeps ready high so a same-cycle offer is swallowed.
      assign in_ready = (rdy_q | flush) & ~reset;

      always_ff @(posedge clk) begin
        if (reset || flush)
          skid_q <= NOP_VALUE;
        else if (state_q == ONE && accept && !drain)
          skid_q <= in_data;
      end
    end else begin : g_noskid
      assign in_ready = (~out_valid | out_ready | flush) & ~reset;
      assign skid_q   = NOP_VALUE;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept && SKID != 0) begin
            state_d = FULL;
          end else if (drain) begin
            state_d = EMPTY;
            main_d  = NOP_VALUE;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
        end
      endcase
    end
  end

  // main holds NOP_VALUE whenever empty, so out_data needs no output mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width in bits (one 16-bit PC plus one 16-bit instruction).
REQ-002 Parameter SKID, default 1, SHALL select the buffer depth: 1 gives a 2-entry skid buffer, 0 gives a single register.
REQ-003 Parameter NOP_VALUE, default all-zero, SHALL set the bubble value DATA_W wide that is driven when no data is held.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: synchronous and active-high.
REQ-006 in_valid  input  1  SHALL mean the upstream stage offers in_data this cycle.
REQ-007 in_data  input  DATA_W  SHALL carry the upstream payload.
REQ-008 in_ready  output  1  SHALL mean the block accepts in_data this cycle.
REQ-009 out_valid  output  1  SHALL mean out_data holds a real payload.
REQ-010 out_data  output  DATA_W  SHALL carry the downstream payload, or NOP_VALUE when out_valid=0.
REQ-011 out_ready  input  1  SHALL mean the downstream stage consumes out_data this cycle.
REQ-012 flush  input  1  SHALL discard all held entries and insert a bubble.
REQ-013 occupancy  output  2  SHALL report the entries held: 0, 1 or 2.

Function
REQ-014 accept = in_valid & in_ready and drain = out_valid & out_ready SHALL be the only transfer events.
REQ-015 Latency SHALL be 1 cycle: data accepted on edge N SHALL appear on out_data after edge N when the block was EMPTY.
REQ-016 With SKID=1, the states SHALL be EMPTY(0), ONE(1) and FULL(2), held in an occupancy register.
REQ-017 EMPTY: on accept -> ONE with main<=in_data; otherwise stay in EMPTY.
REQ-018 ONE: on accept and drain -> ONE with main<=in_data; accept only -> FULL with skid<=in_data; drain only -> EMPTY; neither -> hold.
REQ-019 FULL: on drain -> ONE with main<=skid; otherwise hold; accept SHALL be impossible.
REQ-020 With SKID=1, in_ready SHALL be registered, equal to (occupancy!=2), and have no combinational path from out_ready.
REQ-021 With SKID=0, in_ready SHALL be !out_valid | out_ready (combinational), with states EMPTY and ONE only.
REQ-022 Order SHALL be preserved, with no loss or duplication of any accepted payload.
REQ-023 out_valid SHALL equal (occupancy!=0), and out_data SHALL be driven from the main entry only.
REQ-024 flush SHALL have priority over accept and drain: on the next edge the block SHALL be EMPTY with out_data=NOP_VALUE, and any same-cycle accept SHALL be discarded.
REQ-025 in_ready SHALL stay asserted during flush, so an upstream offer in that cycle is consumed and dropped.
REQ-026 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-027 While reset=1, on each rising edge: occupancy=0, out_valid=0, out_data=NOP_VALUE, skid entry cleared.
REQ-028 in_ready SHALL be forced to 0 while reset=1 and SHALL be 1 on the first cycle after reset deasserts.
REQ-029 Reset SHALL take priority over flush and all transfers, including when asserted mid-operation in FULL.

Structure
REQ-030 WORD_SIZE, NOP_VALUE and the occupancy state encoding (EMPTY/ONE/FULL) SHALL live in the shared opcodes package/header.
REQ-031 No sub-module SHALL be required; the skid entry SHALL be generated only when SKID=1.
REQ-032 The block SHALL replace the fixed IF/ID register and be reusable for the ID/EX, EX/MEM and MEM/WB stages.

Verification
REQ-033 Reset then idle: reset=1 for 2 cycles -> out_valid=0, out_data=NOP_VALUE, occupancy=0; the cycle after release in_ready=1.
REQ-034 Streaming: in_valid=1 with 0x0001..0x0008 each cycle and out_ready=1 -> out_data follows one cycle later, 8 transfers in 8 cycles, occupancy stays 1.
REQ-035 Backpressure: out_ready=0 while offering 0xA, 0xB -> occupancy=2 and in_ready=0; then out_ready=1 -> out 0xA, then 0xB, no loss.
REQ-036 Flush in FULL: holding 0xA, 0xB with flush=1 and in_valid=1 carrying 0xC -> next cycle occupancy=0, out_data=NOP_VALUE, and 0xC is never output.
REQ-037 Reset mid-operation: in FULL, reset=1 for 1 cycle -> occupancy=0 and out_valid=0; the next accepted 0x5 is output with 1-cycle latency.
REQ-038 SKID=0 instance: out_ready=0 after one accept -> in_ready=0; with out_ready=1 the same cycle -> in_ready=1 and back-to-back throughput holds.
